// File: rtl/pulse_train_scheduler.sv
// Pulse train generator: on a start edge, emits cfg_count mark/space pulses
// timed in prescaled ticks. cfg_count=0 repeats until stop is asserted.
module pulse_train_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [3:0]       cfg_prescale,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic [3:0]       presc_q, presc_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       pre_q, pre_d;

  logic start_edge;
  logic launch;
  logic tick_now;

  always_comb begin
    start_edge   = start & ~start_prev_q;
    launch       = (state_q == IDLE) && start_edge && !stop;
    tick_now     = (presc_q == pre_q);

    state_d      = state_q;
    start_prev_d = start;
    presc_d      = presc_q;
    tick_cnt_d   = tick_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    done_d       = 1'b0;
    high_d       = high_q;
    low_d        = low_q;
    count_d      = count_q;
    pre_d        = pre_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          high_d      = cfg_high;
          low_d       = cfg_low;
          count_d     = cfg_count;
          pre_d       = cfg_prescale;
          pulse_cnt_d = '0;
          presc_d     = '0;
          tick_cnt_d  = '0;
          state_d     = MARK;
        end
      end

      MARK: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick_now) begin
          presc_d = '0;
          if (tick_cnt_q == high_q) begin
            tick_cnt_d  = '0;
            pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            state_d     = SPACE;
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end else begin
          presc_d = presc_q + 4'd1;
        end
      end

      SPACE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick_now) begin
          presc_d = '0;
          if (tick_cnt_q == low_q) begin
            tick_cnt_d = '0;
            // pulse_cnt already includes the pulse whose space is ending
            if ((count_q != '0) && (pulse_cnt_q == count_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = MARK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end
        end else begin
          presc_d = presc_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: reset to a quiet idle with a cleared start history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      presc_q      <= '0;
      tick_cnt_q   <= '0;
      pulse_cnt_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      presc_q      <= presc_d;
      tick_cnt_q   <= tick_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      done_q       <= done_d;
    end
  end

  // Latched configuration is only consulted while busy, so it needs no reset
  always_ff @(posedge clk) begin
    high_q  <= high_d;
    low_q   <= low_d;
    count_q <= count_d;
    pre_q   <= pre_d;
  end

  assign pulse_out = (state_q == MARK);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Bench for pulse_train_scheduler: per-cycle expected outputs are queued from
// closed-form pulse timing and compared one entry per clock.
module tb_pulse_train_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] cfg_high, cfg_low, cfg_count;
  logic [3:0] cfg_prescale;
  logic       pulse_out, busy, done;
  logic [7:0] pulse_cnt;

  pulse_train_scheduler #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_count(cfg_count),
    .cfg_prescale(cfg_prescale),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [7:0] c;
  } obs_t;

  typedef struct {
    int h; int l; int p; int c; int len; int fcnt;
  } vec_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_at = -1;
  int   launch_at = 0;

  task automatic push(input logic p, input logic b, input logic d, input int c);
    obs_t o;
    o.p = p; o.b = b; o.d = d; o.c = 8'(c);
    exp_q.push_back(o);
  endtask

  task automatic push_train(input int h, input int l, input int p, input int n,
                            input bit with_done);
    for (int k = 0; k < n; k++) begin
      repeat ((h + 1) * (p + 1)) push(1'b1, 1'b1, 1'b0, k);
      repeat ((l + 1) * (p + 1)) push(1'b0, 1'b1, 1'b0, k + 1);
    end
    if (with_done) push(1'b0, 1'b0, 1'b1, n);
  endtask

  task automatic tick(input string name);
    obs_t act, ex;
    @(posedge clk);
    #1;
    cyc++;
    act = {pulse_out, busy, done, pulse_cnt};
    if (done === 1'b1) done_at = cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc=%0d: no expected entry queued, got pulse=%b busy=%b done=%b cnt=%0d",
               name, cyc, act.p, act.b, act.d, act.c);
    end else begin
      ex = exp_q.pop_front();
      if (act !== ex) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pulse=%b busy=%b done=%b cnt=%0d, expected pulse=%b busy=%b done=%b cnt=%0d",
                 name, cyc, act.p, act.b, act.d, act.c, ex.p, ex.b, ex.d, ex.c);
      end
    end
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) tick(name);
  endtask

  task automatic set_cfg(input int h, input int l, input int p, input int c);
    cfg_high = 8'(h); cfg_low = 8'(l); cfg_prescale = 4'(p); cfg_count = 8'(c);
  endtask

  // Continuous train stopped during the first MARK cycle of pulse n+1
  task automatic run_cont(input int h, input int l, input int p, input int n);
    set_cfg(h, l, p, 0);
    start = 1'b1;
    push_train(h, l, p, n, 1'b0);
    push(1'b1, 1'b1, 1'b0, n);
    tick("cont_launch");
    start = 1'b0;
    drain("cont_run");
    stop = 1'b1;
    push(1'b0, 1'b0, 1'b0, n);
    tick("cont_stop");
    stop = 1'b0;
    repeat (2) push(1'b0, 1'b0, 1'b0, n);
    drain("cont_after_stop");
  endtask

  vec_t tv[5];

  initial begin
    tv[0] = '{1, 2, 0, 3, 15, 3};
    tv[1] = '{0, 0, 3, 1, 8, 1};
    tv[2] = '{2, 0, 1, 2, 16, 2};
    tv[3] = '{0, 1, 0, 4, 12, 4};
    tv[4] = '{0, 0, 15, 1, 32, 1};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) push(1'b0, 1'b0, 1'b0, 0);
    drain("reset");
    rst = 1'b0;
    repeat (2) push(1'b0, 1'b0, 1'b0, 0);
    drain("idle");

    // Finite trains; cfg scrambled and start toggled while busy
    for (int i = 0; i < 5; i++) begin
      set_cfg(tv[i].h, tv[i].l, tv[i].p, tv[i].c);
      start = 1'b1;
      push_train(tv[i].h, tv[i].l, tv[i].p, tv[i].c, 1'b1);
      launch_at = cyc;
      done_at = -1;
      tick("train_launch");
      start = 1'b0;
      cfg_high = 8'($urandom); cfg_low = 8'($urandom);
      cfg_count = 8'($urandom); cfg_prescale = 4'($urandom);
      while (exp_q.size() > 0) begin
        if (exp_q.size() > 2) start = ~start;
        else start = 1'b0;
        tick("train_run");
      end
      checks++;
      if (done_at - launch_at != tv[i].len + 1) begin
        errors++;
        $display("FAIL done_latency vec=%0d: got %0d cycles, expected %0d",
                 i, done_at - launch_at, tv[i].len + 1);
      end
      checks++;
      if (pulse_cnt !== 8'(tv[i].fcnt)) begin
        errors++;
        $display("FAIL final_cnt vec=%0d: got %0d, expected %0d", i, pulse_cnt, tv[i].fcnt);
      end
      repeat (2) push(1'b0, 1'b0, 1'b0, tv[i].fcnt);
      drain("train_idle");
    end

    run_cont(1, 1, 0, 4);
    run_cont(0, 0, 0, 257);

    // Stop during SPACE
    set_cfg(0, 2, 0, 0);
    start = 1'b1;
    push(1'b1, 1'b1, 1'b0, 0);
    push(1'b0, 1'b1, 1'b0, 1);
    drain("space_stop_run");
    start = 1'b0;
    stop = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1);
    tick("space_stop");
    stop = 1'b0;

    // Stop beats a start edge in IDLE; held start does not relaunch
    set_cfg(0, 0, 0, 2);
    start = 1'b1; stop = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1);
    tick("stop_vs_start");
    stop = 1'b0;
    repeat (2) push(1'b0, 1'b0, 1'b0, 1);
    drain("held_start_idle");
    start = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1);
    tick("start_low");
    start = 1'b1;
    push_train(0, 0, 0, 2, 1'b1);
    repeat (3) push(1'b0, 1'b0, 1'b0, 2);
    drain("held_start_train");
    start = 1'b0;
    push(1'b0, 1'b0, 1'b0, 2);
    tick("held_start_end");

    // Reset mid-SPACE with start held across release
    set_cfg(1, 3, 0, 2);
    start = 1'b1;
    push_train(1, 3, 0, 2, 1'b1);
    tick("rst_train");
    start = 1'b0;
    repeat (3) tick("rst_train");
    exp_q.delete();
    rst = 1'b1; stop = 1'b1; start = 1'b1;
    repeat (2) push(1'b0, 1'b0, 1'b0, 0);
    drain("mid_reset");
    rst = 1'b0; stop = 1'b0;
    push_train(1, 3, 0, 2, 1'b1);
    repeat (2) push(1'b0, 1'b0, 1'b0, 2);
    drain("post_reset_train");
    start = 1'b0;
    push(1'b0, 1'b0, 1'b0, 2);
    tick("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_train_scheduler.md
PULSE_TRAIN_SCHEDULER -- requirements
Module: pulse_train_scheduler

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of tick-count and pulse-count fields.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  level request; only its rising edge launches a train.
REQ-005 SHALL have port: stop  input  1  level abort; sampled every cycle.
REQ-006 SHALL have port: cfg_high  input  CNT_W  mark length in ticks, minus 1.
REQ-007 SHALL have port: cfg_low  input  CNT_W  space length in ticks, minus 1.
REQ-008 SHALL have port: cfg_count  input  CNT_W  pulses per train; 0 = continuous.
REQ-009 SHALL have port: cfg_prescale  input  4  clocks per tick, minus 1.
REQ-010 SHALL have port: pulse_out  output  1  generated waveform.
REQ-011 SHALL have port: busy  output  1  high while in MARK or SPACE.
REQ-012 SHALL have port: done  output  1  one-cycle strobe on normal train completion.
REQ-013 SHALL have port: pulse_cnt  output  CNT_W  completed pulses in the current or last train.

Function
REQ-014 Start edge SHALL be start=1 in this cycle AND start=0 in the previous cycle, using one internal register of start.
REQ-015 States SHALL be IDLE, MARK, SPACE; pulse_out=1 only in MARK.
REQ-016 Start edge in IDLE at cycle N (stop=0) SHALL latch all cfg_* inputs, clear pulse_cnt, clear the prescaler, and enter MARK at N+1.
REQ-017 cfg_* changes while busy SHALL have no effect until the next launch.
REQ-018 Prescaler SHALL generate one tick every (cfg_prescale+1) clocks, counted from the first MARK cycle.
REQ-019 MARK SHALL last exactly (cfg_high+1)*(cfg_prescale+1) clocks; SPACE SHALL last exactly (cfg_low+1)*(cfg_prescale+1) clocks.
REQ-020 On each MARK->SPACE transition, pulse_cnt SHALL increment by 1, wrapping modulo 2^CNT_W.
REQ-021 At the end of SPACE, if cfg_count!=0 and pulse_cnt==cfg_count, the FSM SHALL go to IDLE with done=1 for that single cycle; otherwise it SHALL re-enter MARK.
REQ-022 With cfg_count=0 the train SHALL repeat until stop is asserted; done SHALL never assert in this mode.
REQ-023 stop=1 in MARK or SPACE SHALL force IDLE in the next cycle (pulse_out=0, busy=0), with done=0 and pulse_cnt held.
REQ-024 stop=1 with a start edge in IDLE in the same cycle: stop SHALL win and no train SHALL launch.
REQ-025 Start edges while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 Start held high SHALL launch only one train; a new train SHALL require start to go low and then high again.
REQ-027 busy SHALL equal (state!=IDLE), registered, with no combinational path from inputs to any output.

Reset
REQ-028 rst=1 SHALL force state=IDLE, pulse_out=0, busy=0, done=0, pulse_cnt=0, prescaler=0, and start-history register=0.
REQ-029 rst SHALL override stop and start in the same cycle; a mid-train reset SHALL abort with no done strobe.
REQ-030 If start is high in the first cycle after rst deasserts, it SHALL count as a rising edge.

Verification
REQ-031 cfg_high=1, cfg_low=2, cfg_prescale=0, cfg_count=3, start edge at cycle 10 -> pulse_out high at 11-12, 16-17, 21-22; done=1 at cycle 26 only; pulse_cnt=3.
REQ-032 cfg_prescale=3, cfg_high=0, cfg_low=0, cfg_count=1 -> MARK lasts 4 clocks, SPACE lasts 4 clocks, then a single done strobe.
REQ-033 cfg_count=0, stop asserted during the 5th MARK -> next cycle IDLE, pulse_out=0, done=0, pulse_cnt=4.
REQ-034 Start edge in the same cycle as stop in IDLE, then repeated start edges while busy -> no launch in the first case, no extra trains in the second.
REQ-035 rst asserted mid-SPACE with start held high across the reset release -> all outputs 0 during reset; a new train launches one cycle after rst deasserts.
REQ-036 cfg_high changed mid-train -> waveform keeps the latched values; the new value takes effect on the next launch.
